// File: rtl/mul_pkg.sv
// Shared types and operand/result helpers for the RV32M multiply unit.
package mul_pkg;

    localparam int unsigned XlenDef = 32;
    localparam int unsigned TagWDef = 5;

    typedef enum logic [1:0] {
        OpMul    = 2'd0,
        OpMulh   = 2'd1,
        OpMulhsu = 2'd2,
        OpMulhu  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } mul_state_e;

    typedef struct packed {
        mul_op_e              op;
        logic [XlenDef-1:0]   rs1;
        logic [XlenDef-1:0]   rs2;
        logic [TagWDef-1:0]   rd;
    } mul_req_t;

    function automatic logic rs1_signed(mul_op_e op);
        return op != OpMulhu;
    endfunction

    function automatic logic rs2_signed(mul_op_e op);
        return (op == OpMul) || (op == OpMulh);
    endfunction

    // Only MUL returns the low half; every other op returns the high half.
    function automatic logic sel_high(mul_op_e op);
        return op != OpMul;
    endfunction

endpackage

// File: rtl/mul_if.sv
// Issue-side and writeback-side handshake bundle for mul_unit.
interface mul_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    import mul_pkg::*;

    logic             in_valid;
    logic             in_ready;
    mul_op_e          in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_rd;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd
    );

endinterface

// File: rtl/s_multiplier.sv
// Single-cycle registered multiplier: product of two signed WIDTH-bit operands.
module s_multiplier #(
    parameter int unsigned WIDTH = 33
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product
);

    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2*WIDTH-1:0] ext_a, ext_b;

    always_comb begin
        ext_a       = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        ext_b       = {{WIDTH{in_b[WIDTH-1]}}, in_b};
        out_valid_d = in_valid | (out_valid_q & ~out_ready);
        product_d   = in_valid ? ext_a * ext_b : product_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_product = product_q;

endmodule

// File: rtl/mul_unit.sv
// RV32M MUL/MULH/MULHSU/MULHU execution unit around s_multiplier.
// Optional result reuse cache enabled by defining MUL_FUSE_EN.
module mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic  clk,
    input logic  rst,
    input logic  flush,
    mul_if.slave bus
);

    localparam int unsigned MW = XLEN + 1;
    localparam int unsigned PW = 2 * MW;

    mul_state_e       state_q, state_d;
    mul_op_e          op_q, op_d;
    logic [TAG_W-1:0] rd_q, rd_d;
    logic [MW-1:0]    a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic          accept;
    logic          mul_in_valid;
    logic          mul_out_valid;
    logic [PW-1:0] mul_product;
    logic          unused_prod_hi;

    function automatic logic [XLEN-1:0] pick(logic [PW-1:0] p, mul_op_e op);
        return sel_high(op) ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

`ifdef MUL_FUSE_EN
    logic            cache_vld_q, cache_vld_d;
    logic [PW-1:0]   cache_prod_q, cache_prod_d;
    logic [XLEN-1:0] cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
    mul_op_e         cache_op_q, cache_op_d;
    logic            cache_hit;

    // Low half is extension-independent, so MUL may reuse any cached op.
    assign cache_hit = cache_vld_q && (bus.in_rs1 == cache_rs1_q) && (bus.in_rs2 == cache_rs2_q)
                       && ((bus.in_op == OpMul) || (bus.in_op == cache_op_q));
`endif

    assign bus.in_ready = !rst && !flush &&
                          ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_in_valid = (state_q == StIssue) && !flush;
    assign unused_prod_hi = ^mul_product[PW-1:2*XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
`ifdef MUL_FUSE_EN
        cache_vld_d  = cache_vld_q;
        cache_prod_d = cache_prod_q;
        cache_rs1_d  = cache_rs1_q;
        cache_rs2_d  = cache_rs2_q;
        cache_op_d   = cache_op_q;
`endif
        unique case (state_q)
            StIssue: state_d = StWait;
            StWait: begin
                if (mul_out_valid) begin
                    state_d  = StDone;
                    result_d = pick(mul_product, op_q);
`ifdef MUL_FUSE_EN
                    cache_vld_d  = 1'b1;
                    cache_prod_d = mul_product;
                    cache_rs1_d  = a_q[XLEN-1:0];
                    cache_rs2_d  = b_q[XLEN-1:0];
                    cache_op_d   = op_q;
`endif
                end
            end
            StDone: if (bus.out_ready) state_d = StIdle;
            default: ;
        endcase

        if (accept) begin
            op_d    = bus.in_op;
            rd_d    = bus.in_rd;
            a_d     = {rs1_signed(bus.in_op) & bus.in_rs1[XLEN-1], bus.in_rs1};
            b_d     = {rs2_signed(bus.in_op) & bus.in_rs2[XLEN-1], bus.in_rs2};
            state_d = StIssue;
`ifdef MUL_FUSE_EN
            if (cache_hit) begin
                state_d  = StDone;
                result_d = pick(cache_prod_q, bus.in_op);
            end
`endif
        end

        if (flush) begin
            state_d  = StIdle;
            result_d = '0;
`ifdef MUL_FUSE_EN
            cache_vld_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
`ifdef MUL_FUSE_EN
            cache_vld_q  <= 1'b0;
            cache_prod_q <= '0;
            cache_rs1_q  <= '0;
            cache_rs2_q  <= '0;
            cache_op_q   <= OpMul;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
`ifdef MUL_FUSE_EN
            cache_vld_q  <= cache_vld_d;
            cache_prod_q <= cache_prod_d;
            cache_rs1_q  <= cache_rs1_d;
            cache_rs2_q  <= cache_rs2_d;
            cache_op_q   <= cache_op_d;
`endif
        end
    end

    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_result = result_q;
    assign bus.out_rd     = rd_q;

    s_multiplier #(
        .WIDTH(MW)
    ) u_mult (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (mul_in_valid),
        .in_a       (a_q),
        .in_b       (b_q),
        .out_valid  (mul_out_valid),
        .out_ready  (1'b1),
        .out_product(mul_product)
    );

endmodule

// File: doc/mul_unit.md
# mul_unit

Multiply execution unit for the RV32M MUL/MULH/MULHSU/MULHU group. It sits between the issue stage and `s_multiplier`. It accepts one instruction over a ready/valid handshake and sign- or zero-extends both operands to 33 bits. It issues them to `s_multiplier`, captures that block's single-cycle `out_valid` pulse into a result register, and presents the selected 32-bit half with the destination tag on a ready/valid output.

## Interface
- `XLEN`, default 32: operand/result width; the multiplier operand width is `XLEN+1`.
- `TAG_W`, default 5: destination register tag width.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill the in-flight operation (pipeline redirect).
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept.
- `in_op`  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- `in_rs1`, `in_rs2`  in  XLEN  operands.
- `in_rd`  in  TAG_W  destination tag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `out_result`  out  XLEN  selected product half.
- `out_rd`  out  TAG_W  tag of the result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE; reset state is IDLE.
- Accept condition: `in_valid && in_ready`.
- `in_ready = !rst && !flush && (IDLE || (DONE && out_ready))`.
- On accept, register op, rd, and the extended operands, then go to ISSUE.
- Extension of `a`: `rs1` is sign-extended for MUL/MULH/MULHSU and zero-extended for MULHU.
- Extension of `b`: `rs2` is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU.
- ISSUE: drive `s_multiplier` `in_valid=1` for exactly one cycle, then go to WAIT.
- WAIT: on the multiplier `out_valid` pulse, capture the 66-bit product and go to DONE. The pulse is never missed because the unit has no other work pending.
- Result selection: MUL gives `product[XLEN-1:0]`; all other ops give `product[2*XLEN-1:XLEN]`.
- DONE: `out_valid=1`.
  - On `out_ready` with a new accept in the same cycle, go to ISSUE.
  - On `out_ready` without a new accept, go to IDLE.
  - Otherwise hold `out_result`/`out_rd` stable.
- `flush` applies in any state: next state is IDLE, the held result is discarded, and a multiplier pulse arriving that cycle is ignored. `flush` has priority over accept and over output handshake.
- `rst` mid-operation behaves as `flush` and additionally clears all registers.

## Timing
- Reset values: `out_valid=0`, `out_result=0`, `out_rd=0`, `in_ready=0` while `rst` is high and 1 in the first cycle after.
- Latency: accept in cycle N → ISSUE in N+1 → multiplier pulse in N+2 → `out_valid` in N+3.
- Throughput: one operation per 3 cycles with `out_ready` held high, because accept-in-DONE overlaps the output handshake.
- All outputs are registered except `in_ready`.
- `s_multiplier` is instantiated with `WIDTH=XLEN+1`; its `out_ready` is tied to 1.

## Configuration
- `MUL_FUSE_EN` defined:
  - The unit keeps the last completed 66-bit product plus its rs1, rs2, and op.
  - Hit condition: a new request's rs1/rs2 equal the stored values AND (the new op is MUL OR the new op equals the stored op).
  - On a hit, the unit goes from accept directly to DONE with the cached product, so `out_valid` is asserted in N+1.
  - The cache is invalidated by `rst` and `flush`, and is updated only on a DONE reached through WAIT.
- `MUL_FUSE_EN` undefined: no cache and fixed 3-cycle latency.

## Structure
- Shared package `mul_pkg`:
  - `mul_op_e` enum (MUL, MULH, MULHSU, MULHU).
  - `mul_state_e` enum.
  - `mul_req_t` struct (op, rs1, rs2, rd).
- One sub-module: `s_multiplier`, reused unchanged.
- Extension and half-select are combinational functions in `mul_pkg`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), `out_ready=1` → `out_result=0xFFFFFFEB`, `out_valid` asserted exactly 3 cycles after accept, tag echoed.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHU 0x12345678×0x9ABCDEF0 with `out_ready` low for 5 cycles → `out_valid` and `out_result` held stable at 0x0B00EA4E; `in_ready=0` throughout.
- Back-to-back: 4 MULs with `in_valid` and `out_ready` always high → accepts at cycles 0,3,6,9; results in order with correct tags.
- `flush` asserted in WAIT → no `out_valid` for that op, IDLE next cycle; a following MUL 2×3 returns 6 with normal latency.
- With `MUL_FUSE_EN`: MULH 0x00010000×0x00010000 (→0x00000001), then MUL with the same operands → 0x00000000 with `out_valid` 1 cycle after accept. After a `flush`, the same MUL takes 3 cycles.
